// File: rtl/io_bus_pkg.sv
// Shared definitions for the CS/RD/WR strobe bus responder: FSM states,
// register address map and the electrical active level of the strobes.
package io_bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      FAULT = 2'd3
   } state_t;

   localparam logic [1:0] ADDR_PORT0  = 2'd0;
   localparam logic [1:0] ADDR_PORT1  = 2'd1;
   localparam logic [1:0] ADDR_PORT2  = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   // Strobes are active-low on the bus.
   localparam logic STROBE_ACTIVE = 1'b0;

endpackage : io_bus_pkg

// File: rtl/io_strobe_sync.sv
// Multi-stage synchronizer for one asynchronous active-low strobe.
// Resets to 1 so a strobe reads as inactive until the bus is really sampled.
module io_strobe_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_async_n,
   output logic o_sync_n
);

   logic [SYNC_STAGES-1:0] r_sync;

   // Shift the raw strobe through the synchronizer chain.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async_n};
      end
   end

   assign o_sync_n = r_sync[SYNC_STAGES-1];

endmodule : io_strobe_sync

// File: rtl/io_port_responder.sv
// Target end of the CS/RD/WR strobe bus. Synchronizes the strobes, decodes
// read/write cycles, holds three write registers, returns register or status
// data on reads and flags overlapping RD/WR strobes as bus errors.
module io_port_responder
   import io_bus_pkg::*;
#(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              CS_In,
   input  logic              RD_In,
   input  logic              WR_In,
   input  logic [1:0]        Addr_In,
   input  logic [DATA_W-1:0] Data_In,
   input  logic [DATA_W-1:0] Status_In,
   output logic [DATA_W-1:0] Data_Out,
   output logic              Data_OE,
   output logic [DATA_W-1:0] Port0_Out,
   output logic [DATA_W-1:0] Port1_Out,
   output logic [DATA_W-1:0] Port2_Out,
   output logic              Wr_Pulse,
   output logic              Rd_Pulse,
   output logic              Bus_Err
);

   logic w_cs_s, w_rd_s, w_wr_s;
   logic w_cs, w_rd, w_wr;

   state_t r_state, w_next_state;

   logic w_capture, w_commit, w_read_start, w_err, w_data_oe;
   logic [DATA_W-1:0] w_rd_mux;

   logic [1:0]        r_addr;
   logic [DATA_W-1:0] r_hold_data;
   logic [DATA_W-1:0] r_port0, r_port1, r_port2;
   logic [DATA_W-1:0] r_data_out;
   logic              r_wr_pulse, r_rd_pulse, r_bus_err;

   io_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
      .i_clk     (Clk),
      .i_reset   (Reset),
      .i_async_n (CS_In),
      .o_sync_n  (w_cs_s)
   );

   io_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (
      .i_clk     (Clk),
      .i_reset   (Reset),
      .i_async_n (RD_In),
      .o_sync_n  (w_rd_s)
   );

   io_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
      .i_clk     (Clk),
      .i_reset   (Reset),
      .i_async_n (WR_In),
      .o_sync_n  (w_wr_s)
   );

   assign w_cs = (w_cs_s == STROBE_ACTIVE);
   assign w_rd = (w_rd_s == STROBE_ACTIVE);
   assign w_wr = (w_wr_s == STROBE_ACTIVE);

   // State register.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode; violations take priority over normal cycle progress.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_cs && w_rd && w_wr)  w_next_state = FAULT;
            else if (w_cs && w_wr)     w_next_state = WRITE;
            else if (w_cs && w_rd)     w_next_state = READ;
         end
         WRITE: begin
            if (w_rd)                  w_next_state = FAULT;
            else if (!w_wr || !w_cs)   w_next_state = IDLE;
         end
         READ: begin
            if (w_wr)                  w_next_state = FAULT;
            else if (!w_rd || !w_cs)   w_next_state = IDLE;
         end
         FAULT: begin
            if (!w_rd && !w_wr)        w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Per-state control strobes for the datapath.
   always_comb begin
      w_capture    = 1'b0;
      w_commit     = 1'b0;
      w_read_start = 1'b0;
      w_err        = 1'b0;
      w_data_oe    = 1'b0;
      case (r_state)
         IDLE: begin
            w_err        = w_cs && w_rd && w_wr;
            w_capture    = w_cs && w_wr && !w_rd;
            w_read_start = w_cs && w_rd && !w_wr;
         end
         WRITE: begin
            w_err     = w_rd;
            w_capture = !w_rd && w_cs && w_wr;
            w_commit  = !w_rd && (!w_wr || !w_cs);
         end
         READ: begin
            w_data_oe = 1'b1;
            w_err     = w_wr;
         end
         default: ;
      endcase
   end

   // Read-data select from the address latched at the start of the read.
   always_comb begin
      w_rd_mux = '0;
      case (r_addr)
         ADDR_PORT0:  w_rd_mux = r_port0;
         ADDR_PORT1:  w_rd_mux = r_port1;
         ADDR_PORT2:  w_rd_mux = r_port2;
         ADDR_STATUS: w_rd_mux = Status_In;
         default:     w_rd_mux = '0;
      endcase
   end

   // Holding registers, port registers, registered read data and pulses.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_addr      <= '0;
         r_hold_data <= '0;
         r_port0     <= '0;
         r_port1     <= '0;
         r_port2     <= '0;
         r_data_out  <= '0;
         r_wr_pulse  <= 1'b0;
         r_rd_pulse  <= 1'b0;
         r_bus_err   <= 1'b0;
      end else begin
         r_wr_pulse <= w_commit;
         r_rd_pulse <= w_read_start;
         r_bus_err  <= w_err;
         if (w_capture) begin
            r_addr      <= Addr_In;
            r_hold_data <= Data_In;
         end else if (w_read_start) begin
            r_addr <= Addr_In;
         end
         if (w_commit) begin
            case (r_addr)
               ADDR_PORT0: r_port0 <= r_hold_data;
               ADDR_PORT1: r_port1 <= r_hold_data;
               ADDR_PORT2: r_port2 <= r_hold_data;
               default: ;
            endcase
         end
         r_data_out <= w_data_oe ? w_rd_mux : '0;
      end
   end

   assign Data_Out  = r_data_out;
   assign Data_OE   = w_data_oe;
   assign Port0_Out = r_port0;
   assign Port1_Out = r_port1;
   assign Port2_Out = r_port2;
   assign Wr_Pulse  = r_wr_pulse;
   assign Rd_Pulse  = r_rd_pulse;
   assign Bus_Err   = r_bus_err;

endmodule : io_port_responder

// File: tb/tb_io_port_responder.sv
// Scoreboard bench for io_port_responder: stimulus pushes the expected
// response of each bus cycle, a monitor pops and checks on every pulse.
module tb_io_port_responder;

   localparam int unsigned DATA_W = 8;
   localparam int KIND_WR  = 0;
   localparam int KIND_RD  = 1;
   localparam int KIND_ERR = 2;

   typedef struct {
      int         kind;
      logic [7:0] p0;
      logic [7:0] p1;
      logic [7:0] p2;
      logic [7:0] rd_data;
   } exp_t;

   logic              Clk = 1'b0;
   logic              Reset;
   logic              CS_In, RD_In, WR_In;
   logic [1:0]        Addr_In;
   logic [DATA_W-1:0] Data_In, Status_In;
   logic [DATA_W-1:0] Data_Out, Port0_Out, Port1_Out, Port2_Out;
   logic              Data_OE, Wr_Pulse, Rd_Pulse, Bus_Err;

   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t q[$];
   logic [7:0] m_port [3];

   io_port_responder #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .CS_In     (CS_In),
      .RD_In     (RD_In),
      .WR_In     (WR_In),
      .Addr_In   (Addr_In),
      .Data_In   (Data_In),
      .Status_In (Status_In),
      .Data_Out  (Data_Out),
      .Data_OE   (Data_OE),
      .Port0_Out (Port0_Out),
      .Port1_Out (Port1_Out),
      .Port2_Out (Port2_Out),
      .Wr_Pulse  (Wr_Pulse),
      .Rd_Pulse  (Rd_Pulse),
      .Bus_Err   (Bus_Err)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic push(input int kind, input logic [7:0] rd_data);
      exp_t e;
      e.kind = kind; e.p0 = m_port[0]; e.p1 = m_port[1]; e.p2 = m_port[2];
      e.rd_data = rd_data;
      q.push_back(e);
   endtask

   task automatic do_write(input logic [1:0] a, input logic [7:0] d);
      if (a != 2'd3) m_port[a] = d;
      push(KIND_WR, 8'h00);
      Addr_In = a; Data_In = d; CS_In = 1'b0; WR_In = 1'b0;
      cyc(6);
      WR_In = 1'b1; CS_In = 1'b1;
      cyc(4);
   endtask

   task automatic do_read(input logic [1:0] a, input logic [7:0] exp_data);
      push(KIND_RD, exp_data);
      Addr_In = a; CS_In = 1'b0; RD_In = 1'b0;
      cyc(8);
      RD_In = 1'b1; CS_In = 1'b1;
      cyc(4);
      chk("oe_after_rd_release", {31'd0, Data_OE}, 32'd0);
   endtask

   // Monitor: every pulse must match the head of the scoreboard queue.
   initial begin : monitor
      exp_t e;
      logic       rd_pending;
      logic [7:0] rd_exp;
      rd_pending = 1'b0;
      rd_exp     = '0;
      forever begin
         @(negedge Clk);
         if (rd_pending) begin
            chk("rd_data", {24'd0, Data_Out}, {24'd0, rd_exp});
            chk("rd_oe_hold", {31'd0, Data_OE}, 32'd1);
            rd_pending = 1'b0;
         end
         if (!Reset && (Wr_Pulse || Rd_Pulse || Bus_Err)) begin
            if (q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_pulse: got wr=%0b rd=%0b err=%0b expected none (t=%0t)",
                        Wr_Pulse, Rd_Pulse, Bus_Err, $time);
            end else begin
               e = q.pop_front();
               chk("pulse_kind", {29'd0, Bus_Err, Rd_Pulse, Wr_Pulse},
                   (e.kind == KIND_WR) ? 32'd1 : (e.kind == KIND_RD) ? 32'd2 : 32'd4);
               chk("port0", {24'd0, Port0_Out}, {24'd0, e.p0});
               chk("port1", {24'd0, Port1_Out}, {24'd0, e.p1});
               chk("port2", {24'd0, Port2_Out}, {24'd0, e.p2});
               if (e.kind == KIND_RD) begin
                  chk("rd_oe", {31'd0, Data_OE}, 32'd1);
                  rd_pending = 1'b1;
                  rd_exp     = e.rd_data;
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin : stimulus
      m_port[0] = '0; m_port[1] = '0; m_port[2] = '0;
      Reset = 1'b1; CS_In = 1'b1; RD_In = 1'b1; WR_In = 1'b1;
      Addr_In = '0; Data_In = '0; Status_In = '0;
      cyc(3);
      @(negedge Clk);
      chk("rst_port0", {24'd0, Port0_Out}, 32'd0);
      chk("rst_port1", {24'd0, Port1_Out}, 32'd0);
      chk("rst_port2", {24'd0, Port2_Out}, 32'd0);
      chk("rst_oe", {31'd0, Data_OE}, 32'd0);
      chk("rst_dout", {24'd0, Data_Out}, 32'd0);
      chk("rst_pulses", {29'd0, Wr_Pulse, Rd_Pulse, Bus_Err}, 32'd0);
      @(posedge Clk); #1;
      Reset = 1'b0;
      cyc(2);

      // Write 0xA5 to port 1, checking the commit lands exactly 3 cycles after release.
      m_port[1] = 8'hA5;
      push(KIND_WR, 8'h00);
      Addr_In = 2'd1; Data_In = 8'hA5; CS_In = 1'b0; WR_In = 1'b0;
      cyc(6);
      WR_In = 1'b1; CS_In = 1'b1;
      @(posedge Clk); @(posedge Clk);
      @(negedge Clk);
      chk("wr_latency_early", {24'd0, Port1_Out}, 32'd0);
      @(posedge Clk);
      @(negedge Clk);
      chk("wr_latency_exact", {24'd0, Port1_Out}, 32'hA5);
      cyc(3);

      // Port 2 then two reads: register and status.
      do_write(2'd2, 8'h3C);
      Status_In = 8'h55;
      do_read(2'd2, 8'h3C);
      Status_In = 8'h81;
      do_read(2'd3, 8'h81);

      // Write to address 3 is dropped but still pulses.
      do_write(2'd3, 8'hEE);

      // RD overlapping a write: error, no commit, fault held while WR stays low.
      push(KIND_ERR, 8'h00);
      Addr_In = 2'd0; Data_In = 8'h77; CS_In = 1'b0; WR_In = 1'b0;
      cyc(5);
      RD_In = 1'b0;
      cyc(6);
      chk("fault_oe", {31'd0, Data_OE}, 32'd0);
      RD_In = 1'b1;
      cyc(6);
      chk("fault_no_commit", {24'd0, Port0_Out}, 32'd0);
      WR_In = 1'b1; CS_In = 1'b1;
      cyc(4);
      do_write(2'd0, 8'h5A);
      chk("post_fault_write", {24'd0, Port0_Out}, 32'h5A);

      // Reset in the middle of a write aborts it and clears the ports.
      Addr_In = 2'd0; Data_In = 8'hFF; CS_In = 1'b0; WR_In = 1'b0;
      cyc(5);
      Reset = 1'b1;
      m_port[0] = '0; m_port[1] = '0; m_port[2] = '0;
      cyc(2);
      WR_In = 1'b1; CS_In = 1'b1;
      cyc(1);
      Reset = 1'b0;
      cyc(5);
      chk("rst_mid_port0", {24'd0, Port0_Out}, 32'd0);
      chk("rst_mid_oe", {31'd0, Data_OE}, 32'd0);

      // Back-to-back writes with a single synchronized idle cycle between them.
      m_port[0] = 8'h11;
      push(KIND_WR, 8'h00);
      m_port[1] = 8'h22;
      push(KIND_WR, 8'h00);
      Addr_In = 2'd0; Data_In = 8'h11; CS_In = 1'b0; WR_In = 1'b0;
      cyc(6);
      WR_In = 1'b1;
      cyc(1);
      WR_In = 1'b0;
      cyc(2);
      Addr_In = 2'd1; Data_In = 8'h22;
      cyc(6);
      WR_In = 1'b1; CS_In = 1'b1;
      cyc(5);
      chk("b2b_port0", {24'd0, Port0_Out}, 32'h11);
      chk("b2b_port1", {24'd0, Port1_Out}, 32'h22);

      cyc(4);
      chk("scoreboard_drained", q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_io_port_responder

// File: doc/io_port_responder.md
Name: io_port_responder

Overview:
- Peripheral-side end of the CS/RD/WR strobe bus: the target device that the gated chip-select/read/write strobes address.
- Synchronizes the asynchronous active-low strobes into the local clock and decodes read and write cycles.
- Holds three write registers, returns register or status data on reads, and reports protocol violations.
- Sits between the external I/O strobe bus and local peripheral logic.

Parameters:
- DATA_W, 8, width of the data bus and of each port register.
- SYNC_STAGES, 2, flip-flop stages on each of CS_In, RD_In and WR_In (minimum 2).

Ports:
- Clk  input  1  single system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- CS_In  input  1  chip select, active-low, asynchronous to Clk.
- RD_In  input  1  read strobe, active-low, asynchronous.
- WR_In  input  1  write strobe, active-low, asynchronous.
- Addr_In  input  2  register address, stable while CS_In is low.
- Data_In  input  DATA_W  write data from the bus.
- Status_In  input  DATA_W  local status, returned on reads of address 3.
- Data_Out  output  DATA_W  read data to the bus.
- Data_OE  output  1  high while Data_Out is driven; external tristate enable.
- Port0_Out, Port1_Out, Port2_Out  output  DATA_W each  write registers at addresses 0, 1 and 2.
- Wr_Pulse  output  1  one-cycle pulse when a write commits.
- Rd_Pulse  output  1  one-cycle pulse when a read cycle begins.
- Bus_Err  output  1  one-cycle pulse on a protocol violation.

Behaviour:
- **Reset:** Clk is the only clock. Reset is synchronous and active-high. While Reset is high:
  - all sync flops load 1 (strobes inactive);
  - state becomes IDLE;
  - Port0_Out, Port1_Out and Port2_Out clear to 0;
  - Data_Out = 0, Data_OE = 0, and all pulses = 0.
  - Reset asserted mid-cycle aborts the cycle without committing it.
- **Synchronization:** cs_s, rd_s and wr_s are the outputs of the last sync stage. "Active" means the synchronized value is 0.
- **IDLE:**
  - cs_s, rd_s and wr_s all active: Bus_Err pulse, go to FAULT.
  - cs_s and wr_s active: capture Addr_In and Data_In into holding registers, go to WRITE.
  - cs_s and rd_s active: latch Addr_In, Rd_Pulse pulse, go to READ. Data_OE goes high on the next cycle.
- **WRITE:**
  - Re-capture Addr_In and Data_In every cycle while cs_s and wr_s stay active.
  - If rd_s becomes active: Bus_Err pulse, go to FAULT, no commit.
  - If wr_s or cs_s goes inactive: commit the held data to the addressed register, Wr_Pulse pulse, go to IDLE.
  - A write to address 3 is ignored, but Wr_Pulse still pulses.
- **READ:**
  - Data_OE = 1.
  - Data_Out = Port0/1/2 for addresses 0–2, or Status_In for address 3, from the latched address. Registered, so the value updates one cycle after Data_OE rises.
  - If wr_s becomes active: Bus_Err pulse, go to FAULT.
  - If rd_s or cs_s goes inactive: Data_OE = 0 on the next cycle, go to IDLE.
- **FAULT:**
  - Data_OE = 0; no register changes.
  - Stay in FAULT until rd_s and wr_s are both inactive, then go to IDLE.
- **Back-to-back cycles:** a new cycle is accepted only from IDLE. The strobe must be seen inactive for at least one synchronized cycle between cycles.
- **Bus timing requirements:**
  - Strobe low time ≥ SYNC_STAGES+2 Clk periods.
  - Addr_In and Data_In hold ≥ SYNC_STAGES+1 periods after the WR_In rising edge.
- **Latency:** WR_In rising edge to register update takes SYNC_STAGES+1 cycles. RD_In falling edge to valid Data_Out takes SYNC_STAGES+2 cycles.

Decomposition:
- **Shared package (io_bus_pkg):**
  - state encoding: IDLE, WRITE, READ, FAULT;
  - address constants ADDR_PORT0 = 0, ADDR_PORT1 = 1, ADDR_PORT2 = 2, ADDR_STATUS = 3;
  - strobe-active level constant, 0.
- **Sub-module (io_strobe_sync):** a SYNC_STAGES-deep synchronizer with reset value 1, instantiated once per strobe.

Test Plan:
- Reset held 3 cycles with strobes idle → all Port*_Out = 0, Data_OE = 0, no pulses.
- Write: CS low, WR low for 6 cycles, Addr = 1, Data = 0xA5, WR released → Port1_Out = 0xA5 exactly SYNC_STAGES+1 cycles after release, one Wr_Pulse, Port0 and Port2 unchanged.
- Read: after Port2 is written with 0x3C, CS and RD low for 8 cycles, Addr = 2 → Rd_Pulse once, Data_OE high, Data_Out = 0x3C. Then Addr = 3 with Status_In = 0x81 → Data_Out = 0x81. Data_OE drops after RD release.
- Violation: during a write, RD also driven low → one Bus_Err pulse, no commit, FAULT held until both strobes high, then a normal write succeeds.
- Reset asserted mid-write (WR low, Data = 0xFF, Addr = 0) → Port0_Out stays 0, state IDLE, no Wr_Pulse.
- Back-to-back writes to addresses 0 and 1 with 1 synchronized idle cycle between them → both commit, two Wr_Pulses, values correct.
